// File: rtl/proc_mem_responder_pkg.sv
// Shared defaults and FSM state encoding for the processor memory responder.
package proc_mem_responder_pkg;

   localparam int MC_BUSWIDTH    = 16;
   localparam int MC_DEPTH       = 256;
   localparam int MC_BURST_LEN   = 4;
   localparam int MC_WAIT_CYCLES = 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BEAT
   } state_t;

endpackage

// File: rtl/proc_mem_responder_mem_array.sv
// Single-port synchronous RAM with a registered read port and write enable.
module proc_mem_responder_mem_array #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) mem[addr] <= din;
   end

   // Only the output register is reset; the array contents survive reset.
   always_ff @(posedge clk) begin
      if (reset)          dout <= '0;
      else if (en && !we) dout <= mem[addr];
   end

endmodule

// File: rtl/proc_mem_responder.sv
// Serves fixed-length wrapping burst reads/writes from the processor interface
// against an internal word-addressed memory.
module proc_mem_responder
   import proc_mem_responder_pkg::*;
#(
   parameter int BUSWIDTH    = MC_BUSWIDTH,
   parameter int DEPTH       = MC_DEPTH,
   parameter int BURST_LEN   = MC_BURST_LEN,
   parameter int WAIT_CYCLES = MC_WAIT_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                AddrValid,
   input  logic                RW,
   input  logic [BUSWIDTH-1:0] addr,
   input  logic [BUSWIDTH-1:0] wdata,
   output logic [BUSWIDTH-1:0] rdata,
   output logic                rdata_valid,
   output logic                Ready,
   output logic                busy,
   output logic                err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LB = $clog2(BURST_LEN);
   localparam logic [3:0]    WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   localparam logic [LB-1:0] BEAT_LAST = '1;

   state_t        state, state_nxt;
   logic [AW-1:0] base;
   logic          dir;
   logic [3:0]    wait_cnt;
   logic [LB-1:0] beat_cnt;
   logic          in_range;
   logic [AW-1:0] beat_addr, next_beat_addr;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;

   assign in_range = 32'(addr) < 32'(DEPTH);

   // Wrap stays inside the BURST_LEN-aligned block: only the low bits advance.
   assign beat_addr      = {base[AW-1:LB], base[LB-1:0] + beat_cnt};
   assign next_beat_addr = {base[AW-1:LB], base[LB-1:0] + beat_cnt + LB'(1)};

   assign Ready       = (state == BEAT);
   assign busy        = (state != IDLE);
   assign rdata_valid = Ready && !dir;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The RAM read is registered, so each read address goes out one cycle
   // ahead of the beat that returns it.
   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = beat_addr;
      case (state)
         IDLE: begin
            if (AddrValid && in_range) begin
               state_nxt = (WAIT_CYCLES == 0) ? BEAT : WAIT;
               if (WAIT_CYCLES == 0 && !RW) begin
                  mem_en   = 1'b1;
                  mem_addr = addr[AW-1:0];
               end
            end
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nxt = BEAT;
               mem_en    = !dir;
               mem_addr  = base;
            end
         end
         BEAT: begin
            if (dir) begin
               mem_en = 1'b1;
               mem_we = 1'b1;
            end else if (beat_cnt != BEAT_LAST) begin
               mem_en   = 1'b1;
               mem_addr = next_beat_addr;
            end
            if (beat_cnt == BEAT_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (reset) mem_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base     <= '0;
         dir      <= 1'b0;
         wait_cnt <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
      end else begin
         err <= (state == IDLE) && AddrValid && !in_range;
         if (state == IDLE && AddrValid && in_range) begin
            base     <= addr[AW-1:0];
            dir      <= RW;
            wait_cnt <= '0;
            beat_cnt <= '0;
         end
         if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
         if (state == BEAT) beat_cnt <= beat_cnt + LB'(1);
      end
   end

   proc_mem_responder_mem_array #(
      .WIDTH (BUSWIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .din   (wdata),
      .dout  (rdata)
   );

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed bench for proc_mem_responder with default parameters (WAIT_CYCLES=1, BURST_LEN=4).
module tb_proc_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        AddrValid;
   logic        RW;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        Ready;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   proc_mem_responder #(
      .BUSWIDTH    (16),
      .DEPTH       (256),
      .BURST_LEN   (4),
      .WAIT_CYCLES (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .AddrValid   (AddrValid),
      .RW          (RW),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .Ready       (Ready),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, Ready, 0);
      chk({tag, "_rvalid"}, rdata_valid, 0);
   endtask

   // Write burst; abort_at >= 0 raises reset during that beat.
   task automatic wr_burst(input logic [15:0] a, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3, input int abort_at);
      logic [15:0] d [4];
      d = '{d0, d1, d2, d3};
      AddrValid = 1'b1; addr = a; RW = 1'b1;
      step();
      AddrValid = 1'b0;
      chk($sformatf("wr%h_wait_busy", a), busy, 1);
      chk($sformatf("wr%h_wait_ready", a), Ready, 0);
      step();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("wr%h_b%0d_ready", a, k), Ready, 1);
         chk($sformatf("wr%h_b%0d_rvalid", a, k), rdata_valid, 0);
         wdata = d[k];
         if (k == abort_at) begin
            reset = 1'b1;
            step();
            idle_chk($sformatf("wr%h_abort", a));
            chk($sformatf("wr%h_abort_err", a), err, 0);
            chk($sformatf("wr%h_abort_rdata", a), rdata, 0);
            reset = 1'b0;
            return;
         end
         step();
      end
      idle_chk($sformatf("wr%h_end", a));
   endtask

   // Read burst; inject_at >= 0 pulses a write request during that beat.
   task automatic rd_burst(input logic [15:0] a, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input int inject_at);
      logic [15:0] e [4];
      int busy_cycles;
      e = '{e0, e1, e2, e3};
      busy_cycles = 0;
      AddrValid = 1'b1; addr = a; RW = 1'b0;
      step();
      AddrValid = 1'b0;
      chk($sformatf("rd%h_wait_ready", a), Ready, 0);
      if (busy) busy_cycles++;
      step();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rd%h_b%0d_ready", a, k), Ready, 1);
         chk($sformatf("rd%h_b%0d_rvalid", a, k), rdata_valid, 1);
         chk($sformatf("rd%h_b%0d_rdata", a, k), rdata, e[k]);
         chk($sformatf("rd%h_b%0d_err", a, k), err, 0);
         if (busy) busy_cycles++;
         AddrValid = 1'b0;
         if (k == inject_at) begin
            AddrValid = 1'b1; addr = 16'h0000; RW = 1'b1; wdata = 16'hDEAD;
         end
         step();
      end
      AddrValid = 1'b0;
      idle_chk($sformatf("rd%h_end", a));
      chk($sformatf("rd%h_err_end", a), err, 0);
      chk($sformatf("rd%h_rdata_hold", a), rdata, e[3]);
      chk($sformatf("rd%h_busy_cycles", a), busy_cycles, 5);
   endtask

   initial begin
      reset = 1'b1; AddrValid = 1'b0; RW = 1'b0; addr = '0; wdata = '0;
      step();
      step();
      idle_chk("reset");
      chk("reset_err", err, 0);
      chk("reset_rdata", rdata, 0);
      reset = 1'b0;
      step();

      wr_burst(16'h0040, 16'h5040, 16'h5041, 16'h5042, 16'h5043, -1);
      wr_burst(16'h0000, 16'hC000, 16'hC001, 16'hC002, 16'hC003, -1);

      // Reset during beat 2 of a write: beats 0 and 1 persist only.
      wr_burst(16'h0040, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 2);
      rd_burst(16'h0040, 16'h00A0, 16'h00A1, 16'h5042, 16'h5043, -1);

      wr_burst(16'h0010, 16'h1111, 16'h2222, 16'h3333, 16'h4444, -1);
      rd_burst(16'h0010, 16'h1111, 16'h2222, 16'h3333, 16'h4444, -1);
      rd_burst(16'h0012, 16'h3333, 16'h4444, 16'h1111, 16'h2222, -1);

      // Out-of-range request: one-cycle err, nothing else moves.
      AddrValid = 1'b1; addr = 16'h0100; RW = 1'b1; wdata = 16'hBAD0;
      step();
      AddrValid = 1'b0;
      chk("oor_err", err, 1);
      idle_chk("oor");
      step();
      chk("oor_err_drop", err, 0);
      idle_chk("oor_after");
      rd_burst(16'h0000, 16'hC000, 16'hC001, 16'hC002, 16'hC003, -1);

      // Top-of-memory block wraps within 0xFC..0xFF.
      wr_burst(16'h00FE, 16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3, -1);
      rd_burst(16'h00FC, 16'h00B2, 16'h00B3, 16'h00B0, 16'h00B1, -1);
      rd_burst(16'h00FF, 16'h00B1, 16'h00B2, 16'h00B3, 16'h00B0, -1);

      // Request during beat 1 of a read is dropped.
      rd_burst(16'h0010, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1);
      step();
      idle_chk("busyreq_quiet");
      chk("busyreq_err", err, 0);
      rd_burst(16'h0000, 16'hC000, 16'hC001, 16'hC002, 16'hC003, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
